// File: rtl/fdivsqrt_postproc_seq.sv
// Sequential divide/sqrt postprocessor: sticky/U-select for FP, iterative normalise + sign fix for int div/rem.
// Optional flush port enabled by defining FDIVSQRT_POSTPROC_FLUSH_EN.
module fdivsqrt_postproc_seq #(
   parameter int XLEN       = 64,
   parameter int DIVB       = 64,
   parameter int SHIFT_STEP = 8,
   parameter int NSHIFTW    = 7
) (
   input  logic                clk_i,
   input  logic                reset_i,
`ifdef FDIVSQRT_POSTPROC_FLUSH_EN
   input  logic                flush_i,
`endif
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [DIVB+3:0]     ws_i,
   input  logic [DIVB+3:0]     wc_i,
   input  logic [DIVB+3:0]     d_i,
   input  logic [DIVB:0]       first_u_i,
   input  logic [DIVB:0]       first_um_i,
   input  logic                sqrt_i,
   input  logic                int_op_i,
   input  logic                rem_op_i,
   input  logic                w64_i,
   input  logic                special_i,
   input  logic                a_s_i,
   input  logic                b_s_i,
   input  logic                b_zero_i,
   input  logic                a_lt_b_i,
   input  logic [XLEN-1:0]     a_i,
   input  logic [XLEN-1:0]     b_i,
   input  logic [NSHIFTW-1:0]  norm_shift_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [DIVB:0]       um_o,
   output logic                sticky_o,
   output logic [XLEN-1:0]     int_result_o,
   output logic [2:0]          state_o
);

   localparam int WW = DIVB + 4;
   localparam int RW = XLEN + 4;
   localparam logic [NSHIFTW-1:0] STEP = NSHIFTW'(SHIFT_STEP);
   localparam bit W64_EXT = (XLEN == 64);

   // Handshake: a transfer happens on a posedge where valid and ready are both high;
   // in_ready is high in IDLE and mirrors out_ready in DONE, low otherwise.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SUM     = 3'd1,
      S_CORRECT = 3'd2,
      S_SHIFT   = 3'd3,
      S_SIGN    = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   state_e state_q, state_d;
   logic [WW-1:0]      ws_q, wc_q, d_q, sum_q, sum_d, sum_w;
   logic [DIVB:0]      first_u_q, first_um_q, pre_u_q, pre_u_d, pre_u_w, um_q, um_d;
   logic               sqrt_q, int_op_q, rem_op_q, w64_q, special_q;
   logic               a_s_q, b_s_q, b_zero_q, a_lt_b_q;
   logic [XLEN-1:0]    a_q, b_q, int_result_q, int_result_d, res_w;
   logic [NSHIFTW-1:0] ns_q, cnt_q, cnt_d, step_w;
   logic [RW-1:0]      pre_q, pre_d, rem_w;
   logic               neg_q, neg_d, sticky_q, sticky_d;
   logic               in_ready, out_valid, load, div_by_zero;

   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      neg_d        = neg_q;
      pre_u_d      = pre_u_q;
      pre_d        = pre_q;
      cnt_d        = cnt_q;
      um_d         = um_q;
      sticky_d     = sticky_q;
      int_result_d = int_result_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      sum_w        = ws_q + wc_q;
      pre_u_w      = sum_w[WW-1] ? first_um_q : first_u_q;
      rem_w        = sum_q[WW-1 -: RW] + (neg_q ? d_q[WW-1 -: RW] : '0);
      step_w       = (cnt_q < STEP) ? cnt_q : STEP;
      res_w        = pre_q[XLEN-1:0];
      // The raw operand is consulted too, so a zero divisor is caught even if the flag is late.
      div_by_zero  = b_zero_q | (w64_q ? (b_q[31:0] == 32'd0) : (b_q == '0));
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid_i) state_d = S_SUM;
         end
         S_SUM: begin
            sum_d        = sum_w;
            neg_d        = sum_w[WW-1];
            pre_u_d      = pre_u_w;
            um_d         = sqrt_q ? {pre_u_w[DIVB-1:0], 1'b0} : pre_u_w;
            sticky_d     = (sum_w != '0) & ~special_q;
            int_result_d = '0;
            state_d      = int_op_q ? S_CORRECT : S_DONE;
         end
         S_CORRECT: begin
            pre_d   = rem_op_q ? rem_w : {3'b000, pre_u_q[DIVB -: XLEN+1]};
            cnt_d   = ns_q;
            state_d = (ns_q == '0) ? S_SIGN : S_SHIFT;
         end
         S_SHIFT: begin
            pre_d = $signed(pre_q) >>> step_w;
            cnt_d = cnt_q - step_w;
            if (cnt_q == step_w) state_d = S_SIGN;
         end
         S_SIGN: begin
            if (a_s_q ^ (b_s_q & ~rem_op_q)) res_w = -res_w;
            if (div_by_zero)   res_w = rem_op_q ? a_q : '1;
            else if (a_lt_b_q) res_w = rem_op_q ? a_q : '0;
            if (W64_EXT && w64_q) res_w = XLEN'($signed(res_w[31:0]));
            int_result_d = res_w;
            state_d      = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready_i;
            if (out_ready_i) state_d = in_valid_i ? S_SUM : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef FDIVSQRT_POSTPROC_FLUSH_EN
      if (flush_i && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         in_ready  = 1'b0;
         out_valid = 1'b0;
      end
`endif
   end

   assign load = in_valid_i & in_ready;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         ws_q <= '0; wc_q <= '0; d_q <= '0;
         first_u_q <= '0; first_um_q <= '0;
         sqrt_q <= 1'b0; int_op_q <= 1'b0; rem_op_q <= 1'b0; w64_q <= 1'b0; special_q <= 1'b0;
         a_s_q <= 1'b0; b_s_q <= 1'b0; b_zero_q <= 1'b0; a_lt_b_q <= 1'b0;
         a_q <= '0; b_q <= '0; ns_q <= '0;
         sum_q <= '0; neg_q <= 1'b0; pre_u_q <= '0; pre_q <= '0; cnt_q <= '0;
         um_q <= '0; sticky_q <= 1'b0; int_result_q <= '0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         neg_q        <= neg_d;
         pre_u_q      <= pre_u_d;
         pre_q        <= pre_d;
         cnt_q        <= cnt_d;
         um_q         <= um_d;
         sticky_q     <= sticky_d;
         int_result_q <= int_result_d;
         if (load) begin
            ws_q <= ws_i; wc_q <= wc_i; d_q <= d_i;
            first_u_q <= first_u_i; first_um_q <= first_um_i;
            sqrt_q <= sqrt_i; int_op_q <= int_op_i; rem_op_q <= rem_op_i;
            w64_q <= w64_i; special_q <= special_i;
            a_s_q <= a_s_i; b_s_q <= b_s_i; b_zero_q <= b_zero_i; a_lt_b_q <= a_lt_b_i;
            a_q <= a_i; b_q <= b_i; ns_q <= norm_shift_i;
         end
      end
   end

   assign in_ready_o   = in_ready;
   assign out_valid_o  = out_valid;
   assign um_o         = um_q;
   assign sticky_o     = sticky_q;
   assign int_result_o = int_result_q;
   assign state_o      = state_q;

endmodule
